// File: rtl/mem_port_arbiter_pkg.sv
// mem_arb_pkg: shared types and constants for the unified-RAM port arbiter.
//   arb_state_t  - arbiter FSM states
//   requester_t  - identifies the fetch (IF) or load/store (D) port
//   STARVE_LIMIT - consecutive contested D grants before IF is forced through
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RD_RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_D  = 1'b1
  } requester_t;

  localparam logic [1:0] STARVE_LIMIT = 2'd3;

endpackage

// File: rtl/mem_port_arbiter_arb_pick.sv
// arb_pick: combinational winner selection between the IF and D requesters.
// Ports:
//   i_en       - grants permitted this cycle
//   i_if_req   - fetch request
//   i_d_req    - data request
//   i_if_first - IF wins a contested grant (otherwise D wins)
//   o_winner   - selected requester (meaningful only when a gnt is high)
//   o_if_gnt   - fetch grant one-hot bit
//   o_d_gnt    - data grant one-hot bit
module arb_pick
  import mem_arb_pkg::*;
(
  input  logic       i_en,
  input  logic       i_if_req,
  input  logic       i_d_req,
  input  logic       i_if_first,
  output requester_t o_winner,
  output logic       o_if_gnt,
  output logic       o_d_gnt
);

  logic w_pick_if;

  always_comb begin
    w_pick_if = i_if_req && (!i_d_req || i_if_first);
    o_winner  = w_pick_if ? REQ_IF : REQ_D;
    o_if_gnt  = i_en && w_pick_if;
    o_d_gnt   = i_en && i_d_req && !w_pick_if;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares a single-port synchronous-read RAM between the
// instruction-fetch (IF) and load/store (D) requesters using a req/gnt/rvalid
// handshake. Reads return data with rvalid two cycles after the grant; stores
// complete in the grant cycle.
// Ports:
//   clk, rst_n                      - clock, asynchronous active-low reset
//   if_req/if_addr/if_gnt           - fetch request, address, grant
//   if_rvalid/if_rdata              - fetch data pulse and held data
//   d_req/d_we/d_addr/d_wdata/d_gnt - data request, store flag, address, data, grant
//   d_rvalid/d_rdata                - load data pulse and held data
//   ram_addr/ram_wren/ram_wdata     - RAM command
//   ram_rdata                       - RAM read data (one cycle after address)
// Build option: define ARB_ROUND_ROBIN_EN for round-robin arbitration instead
// of fixed D priority with the IF starvation guard.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [WIDTH-1:0]      if_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [WIDTH-1:0]      d_wdata,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [WIDTH-1:0]      d_rdata,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_wren,
  output logic [WIDTH-1:0]      ram_wdata,
  input  logic [WIDTH-1:0]      ram_rdata
);

  arb_state_t            r_state;
  requester_t            r_owner;
  logic [ADDR_WIDTH-1:0] r_rd_addr;
  logic [WIDTH-1:0]      r_if_rdata;
  logic [WIDTH-1:0]      r_d_rdata;
  logic                  r_if_rvalid;
  logic                  r_d_rvalid;

  logic       w_grant_en;
  logic       w_if_first;
  requester_t w_winner;
  logic       w_if_gnt;
  logic       w_d_gnt;
  logic       w_rd_grant;

  // Grants are blocked while reset is held so nothing leaks out during reset.
  assign w_grant_en = rst_n && (r_state != RD_WAIT);

`ifdef ARB_ROUND_ROBIN_EN
  requester_t r_last_winner;

  assign w_if_first = (r_last_winner == REQ_D);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_winner <= REQ_IF;
    end else if (w_if_gnt || w_d_gnt) begin
      r_last_winner <= w_winner;
    end
  end
`else
  logic [1:0] r_starve_cnt;

  assign w_if_first = (r_starve_cnt == STARVE_LIMIT);

  // Counts consecutive D grants while fetch is waiting; saturates at the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve_cnt <= '0;
    end else if (!if_req || w_if_gnt) begin
      r_starve_cnt <= '0;
    end else if (w_d_gnt && (r_starve_cnt != STARVE_LIMIT)) begin
      r_starve_cnt <= r_starve_cnt + 2'd1;
    end
  end
`endif

  arb_pick u_arb_pick (
    .i_en       (w_grant_en),
    .i_if_req   (if_req),
    .i_d_req    (d_req),
    .i_if_first (w_if_first),
    .o_winner   (w_winner),
    .o_if_gnt   (w_if_gnt),
    .o_d_gnt    (w_d_gnt)
  );

  assign w_rd_grant = w_if_gnt || (w_d_gnt && !d_we);

  always_comb begin
    ram_wren  = w_d_gnt && d_we;
    ram_wdata = d_wdata;
    if (r_state == RD_WAIT) begin
      ram_addr = r_rd_addr;
    end else if (w_d_gnt) begin
      ram_addr = d_addr;
    end else begin
      ram_addr = if_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_owner     <= REQ_IF;
      r_rd_addr   <= '0;
      r_if_rdata  <= '0;
      r_d_rdata   <= '0;
      r_if_rvalid <= 1'b0;
      r_d_rvalid  <= 1'b0;
    end else begin
      r_if_rvalid <= 1'b0;
      r_d_rvalid  <= 1'b0;
      case (r_state)
        IDLE, RD_RESP: begin
          if (w_rd_grant) begin
            r_state   <= RD_WAIT;
            r_owner   <= w_winner;
            // ram_addr already carries the winner's address in a grant cycle.
            r_rd_addr <= ram_addr;
          end else begin
            r_state <= IDLE;
          end
        end
        RD_WAIT: begin
          r_state <= RD_RESP;
          if (r_owner == REQ_D) begin
            r_d_rdata  <= ram_rdata;
            r_d_rvalid <= 1'b1;
          end else begin
            r_if_rdata  <= ram_rdata;
            r_if_rvalid <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign if_gnt    = w_if_gnt;
  assign d_gnt     = w_d_gnt;
  assign if_rvalid = r_if_rvalid;
  assign d_rvalid  = r_d_rvalid;
  assign if_rdata  = r_if_rdata;
  assign d_rdata   = r_d_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed plus randomized self-checking bench for
// mem_port_arbiter (default fixed-priority build) with a behavioural RAM and a
// shadow memory holding the contents every read is expected to return.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0;
  logic [9:0]  if_addr = '0;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [9:0]  d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic [9:0]  ram_addr;
  logic        ram_wren;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem    [0:1023];
  logic [31:0] shadow [0:1023];
  logic        pre_we = 1'b0;
  logic [9:0]  pre_addr = '0;
  logic [31:0] pre_data = '0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.WIDTH(32), .ADDR_WIDTH(10)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .ram_addr  (ram_addr),
    .ram_wren  (ram_wren),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  // Synchronous-read single-port RAM; pre_we is a bench-only preload path.
  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (ram_wren) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  // Requesters must hold req until granted.
  logic p_if = 1'b0;
  logic p_d  = 1'b0;
  always @(posedge clk) begin
    if (!rst_n) begin
      p_if = 1'b0;
      p_d  = 1'b0;
    end else begin
      assert (!(p_if && !if_req)) else begin
        bad++;
        $error("FAIL proto.if_req observed=0 expected=1");
      end
      assert (!(p_d && !d_req)) else begin
        bad++;
        $error("FAIL proto.d_req observed=0 expected=1");
      end
      p_if = if_req && !if_gnt;
      p_d  = d_req && !d_gnt;
    end
  end

  initial begin
    #400000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue a read and expect a single rvalid exactly 2 cycles after the grant.
  task automatic read_txn(input bit is_d, input logic [9:0] a, input string tag,
                          output int wait_cyc);
    bit          got;
    int          lat;
    int          n;
    logic [31:0] data;
    if (is_d) begin d_req = 1'b1; d_we = 1'b0; d_addr = a; end
    else begin if_req = 1'b1; if_addr = a; end
    got = 1'b0;
    wait_cyc = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (is_d ? d_gnt : if_gnt) got = 1'b1;
      else begin wait_cyc++; tick(); end
    end
    check1({tag, ".gnt"}, got, 1'b1);
    check1({tag, ".other_gnt"}, is_d ? if_gnt : d_gnt, 1'b0);
    check1({tag, ".wren"}, ram_wren, 1'b0);
    check32({tag, ".ram_addr"}, {22'd0, ram_addr}, {22'd0, a});
    tick();
    if (is_d) d_req = 1'b0; else if_req = 1'b0;
    lat = 0;
    n = 0;
    data = '0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (is_d ? d_rvalid : if_rvalid) begin
        n++;
        lat = k;
        data = is_d ? d_rdata : if_rdata;
      end
      tick();
    end
    check32({tag, ".latency"}, lat, 2);
    check32({tag, ".pulses"}, n, 1);
    check32({tag, ".rdata"}, data, shadow[a]);
    check32({tag, ".held"}, is_d ? d_rdata : if_rdata, shadow[a]);
  endtask

  task automatic store_txn(input logic [9:0] a, input logic [31:0] dat, input string tag);
    int n;
    d_req = 1'b1; d_we = 1'b1; d_addr = a; d_wdata = dat;
    @(negedge clk);
    check1({tag, ".gnt"}, d_gnt, 1'b1);
    check1({tag, ".wren"}, ram_wren, 1'b1);
    check32({tag, ".ram_addr"}, {22'd0, ram_addr}, {22'd0, a});
    check32({tag, ".ram_wdata"}, ram_wdata, dat);
    shadow[a] = dat;
    tick();
    d_req = 1'b0; d_we = 1'b0;
    n = 0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (d_rvalid || ram_wren) n++;
      tick();
    end
    check32({tag, ".no_rvalid"}, n, 0);
  endtask

  bit   order [8];
  int   gcyc  [8];
  int   ng, both, idle, w, nbad;
  bit   g_if, g_d;
  int   kind;
  logic [9:0]  ra;
  logic [31:0] rd;

  initial begin
    // Reset behaviour with both requests asserted.
    if_req = 1'b1; if_addr = 10'd4;
    d_req = 1'b1; d_we = 1'b1; d_addr = 10'd3; d_wdata = 32'hA5A5A5A5;
    @(posedge clk); #1;
    @(negedge clk);
    check1("rst.if_gnt", if_gnt, 1'b0);
    check1("rst.d_gnt", d_gnt, 1'b0);
    check1("rst.wren", ram_wren, 1'b0);
    check1("rst.if_rvalid", if_rvalid, 1'b0);
    check1("rst.d_rvalid", d_rvalid, 1'b0);
    check32("rst.if_rdata", if_rdata, 32'd0);
    check32("rst.d_rdata", d_rdata, 32'd0);
    tick();
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;

    for (int i = 0; i < 64; i++) begin
      pre_we = 1'b1;
      pre_addr = 10'(i);
      pre_data = (i == 4) ? 32'hDEADBEEF : $urandom;
      shadow[i] = pre_data;
      tick();
    end
    pre_we = 1'b0;
    rst_n = 1'b1;
    tick();

    read_txn(1'b0, 10'h004, "fetch4", w);
    check32("fetch4.wait", w, 0);

    store_txn(10'h010, 32'h12345678, "st10");
    read_txn(1'b1, 10'h010, "ld10", w);

    // Back-to-back loads: grant at 0 and 2, rvalid at 2 and 4.
    d_req = 1'b1; d_we = 1'b0; d_addr = 10'h001;
    @(negedge clk);
    check1("b2b.gnt0", d_gnt, 1'b1);
    tick();
    d_addr = 10'h002;
    @(negedge clk);
    check1("b2b.gnt1", d_gnt, 1'b0);
    check1("b2b.rv1", d_rvalid, 1'b0);
    tick();
    @(negedge clk);
    check1("b2b.rv2", d_rvalid, 1'b1);
    check32("b2b.data2", d_rdata, shadow[1]);
    check1("b2b.gnt2", d_gnt, 1'b1);
    tick();
    d_req = 1'b0;
    @(negedge clk);
    check1("b2b.rv3", d_rvalid, 1'b0);
    tick();
    @(negedge clk);
    check1("b2b.rv4", d_rvalid, 1'b1);
    check32("b2b.data4", d_rdata, shadow[2]);
    tick();
    tick();

    // Continuous contention: every fourth grant goes to IF.
    if_req = 1'b1; if_addr = 10'd5;
    d_req = 1'b1; d_we = 1'b0; d_addr = 10'd6;
    ng = 0; both = 0; idle = 0;
    for (int c = 0; c < 60 && idle < 4; c++) begin
      @(negedge clk);
      if (if_gnt && d_gnt) both++;
      if (if_rvalid) check32("cont.if_rdata", if_rdata, shadow[5]);
      if (d_rvalid) check32("cont.d_rdata", d_rdata, shadow[6]);
      g_if = if_gnt;
      g_d = d_gnt;
      if ((g_if || g_d) && ng < 8) begin
        order[ng] = g_d;
        gcyc[ng] = c;
        ng++;
      end
      tick();
      if (ng >= 8) begin
        if (g_if) if_req = 1'b0;
        if (g_d) d_req = 1'b0;
      end
      if (!if_req && !d_req) idle++;
    end
    check32("cont.ngrants", ng, 8);
    check32("cont.double_gnt", both, 0);
    check1("cont.drained", if_req || d_req, 1'b0);
    if_req = 1'b0; d_req = 1'b0;
    for (int i = 0; i < 8; i++)
      check1($sformatf("cont.order%0d_is_d", i), order[i], (i % 4) != 3);
    nbad = 0;
    for (int i = 1; i < 8; i++)
      if (gcyc[i] - gcyc[i-1] != 2) nbad++;
    check32("cont.spacing", nbad, 0);
    tick();

    // Reset while a fetch is in RD_WAIT aborts it.
    if_req = 1'b1; if_addr = 10'h004;
    @(negedge clk);
    check1("rstrd.gnt", if_gnt, 1'b1);
    tick();
    rst_n = 1'b0;
    d_req = 1'b1; d_we = 1'b1; d_addr = 10'h008; d_wdata = 32'h0BADF00D;
    #2;
    check1("rstrd.if_gnt", if_gnt, 1'b0);
    check1("rstrd.d_gnt", d_gnt, 1'b0);
    check1("rstrd.wren", ram_wren, 1'b0);
    check32("rstrd.if_rdata", if_rdata, 32'd0);
    nbad = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (if_rvalid || d_rvalid || if_gnt || d_gnt || ram_wren) nbad++;
      tick();
    end
    check32("rstrd.quiet", nbad, 0);
    rst_n = 1'b1;
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    nbad = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (if_rvalid || d_rvalid) nbad++;
      tick();
    end
    check32("rstrd.stale_rvalid", nbad, 0);
    check32("rstrd.if_rdata_after", if_rdata, 32'd0);
    read_txn(1'b0, 10'h007, "rstrd.fetch7", w);
    check32("rstrd.idle_wait", w, 0);

    // Randomized single transactions against the shadow memory.
    for (int t = 0; t < 40; t++) begin
      kind = $urandom_range(0, 2);
      ra = 10'($urandom_range(0, 63));
      rd = $urandom;
      case (kind)
        0: read_txn(1'b0, ra, $sformatf("rnd%0d.fetch", t), w);
        1: read_txn(1'b1, ra, $sformatf("rnd%0d.load", t), w);
        default: store_txn(ra, rd, $sformatf("rnd%0d.store", t));
      endcase
      if (kind != 2) check32($sformatf("rnd%0d.wait", t), w, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port, synchronous-read unified RAM between two requesters: instruction fetch (IF port) and load/store (D port).
- Sits between the multicycle controller/datapath and the RAM.
- Grants one access per transaction and returns read data with a single-cycle valid pulse.
- Replaces ad-hoc delay states in the controller with an explicit req/gnt/rvalid handshake.

Parameters:
- WIDTH, 32, data word width in bits.
- ADDR_WIDTH, 10, RAM word-address width in bits.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- if_req  in  1  fetch request. Held with if_addr until if_gnt.
- if_addr  in  ADDR_WIDTH  fetch word address.
- if_gnt  out  1  fetch accepted this cycle. Combinational.
- if_rvalid  out  1  one-cycle pulse: if_rdata holds new fetch data.
- if_rdata  out  WIDTH  registered fetch data. Held until the next if_rvalid.
- d_req  in  1  data request. Held with d_we, d_addr and d_wdata until d_gnt.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_WIDTH  data word address.
- d_wdata  in  WIDTH  store data.
- d_gnt  out  1  data request accepted this cycle. Combinational.
- d_rvalid  out  1  one-cycle pulse: d_rdata holds new load data. Never pulses for stores.
- d_rdata  out  WIDTH  registered load data. Held until the next d_rvalid.
- ram_addr  out  ADDR_WIDTH  RAM address.
- ram_wren  out  1  RAM write enable.
- ram_wdata  out  WIDTH  RAM write data.
- ram_rdata  in  WIDTH  RAM read data, valid the cycle after the address is presented.

Behaviour:
- Reset (rst_n low, asynchronous): state = IDLE; owner = IF; rdata registers = 0; rvalid = 0. While in reset, gnt = 0 and ram_wren = 0.
- States:
  - IDLE: accepting requests.
  - RD_WAIT: one read outstanding.
  - RD_RESP: read data is captured.
- IDLE:
  - If any req, grant exactly one winner (arbitration below) in the same cycle.
  - Drive ram_addr, ram_wren and ram_wdata from the winner combinationally.
  - A winning store: ram_wren = 1 for that cycle only; stay in IDLE. Stores are complete at grant.
  - A winning read: record the owner, go to RD_WAIT.
- RD_WAIT:
  - No grants.
  - ram_addr holds the registered read address.
  - On the next edge: capture ram_rdata into the owner's rdata register, go to RD_RESP.
- RD_RESP:
  - Owner's rvalid = 1 for exactly this cycle.
  - Grants are allowed here as in IDLE, so back-to-back reads cost 2 cycles each.
  - Next state: RD_WAIT if a read is granted, else IDLE.
- Read latency: gnt at cycle N, rvalid and rdata at cycle N+2.
- Default arbitration, fixed priority: D beats IF.
- Starvation guard:
  - A 2-bit counter counts consecutive D grants made while if_req is high.
  - When the counter reaches 3, IF wins the next contested grant.
  - The counter clears on any IF grant or when if_req is low.
- Simultaneous events: both reqs in one cycle produce exactly one gnt. gnt never asserts without its req.
- A requester dropping req before gnt is a protocol violation and is not handled. Covered by an assertion in the bench.
- ram_wren is 0 outside granted store cycles. ram_addr defaults to if_addr when idle.
- Reset during RD_WAIT or RD_RESP aborts the read: no rvalid is ever issued for it.

Optional Feature:
- ARB_ROUND_ROBIN_EN defined:
  - Replaces fixed priority and the starvation counter with round-robin.
  - A last_winner register, reset to IF, is updated on every grant.
  - On a contested grant, the port that did not win last wins.
- Undefined: fixed D-priority with the starvation guard, as above.

Decomposition:
- Package mem_arb_pkg:
  - typedef arb_state_t {IDLE, RD_WAIT, RD_RESP}.
  - typedef requester_t {REQ_IF, REQ_D}.
  - localparam STARVE_LIMIT = 3.
- One natural sub-module: arb_pick. Purely combinational; inputs are the two reqs plus priority state; output is the winner and gnt one-hots. Instantiated once.
- The FSM, datapath registers and counter stay in mem_port_arbiter.

Test Plan:
- if_req=1, if_addr=0x004, RAM[4]=0xDEADBEEF -> if_gnt at cycle 0; if_rvalid pulse at cycle 2; if_rdata=0xDEADBEEF, held after the pulse.
- d_req=1, d_we=1, d_addr=0x010, d_wdata=0x12345678 -> d_gnt and ram_wren=1 for one cycle, no d_rvalid; a subsequent load of 0x010 returns 0x12345678.
- if_req and d_req (load) both held high continuously (fixed priority) -> grant order D, D, D, IF, D, D, D, IF; never two gnts in one cycle.
- With ARB_ROUND_ROBIN_EN, same stimulus -> grants alternate IF, D, IF, D; a read is granted every 2 cycles.
- Assert rst_n low during RD_WAIT of a fetch -> gnts and rvalids 0; if_rdata=0; state IDLE after release; no stale rvalid.
- Back-to-back loads to 0x001 and 0x002 -> d_rvalid at cycles 2 and 4, with the correct data for each.
